vend_ctrl_param: RTL and testbench
==================================

// Module: vend_ctrl_param
// PURPOSE
//  Parametrised vending-machine controller; next generation of the fixed 5-item coin FSM.
//  Accumulates nickel/dime/quarter credit up to MAX_CREDIT. Prices any of N_ITEMS x quantity.
//  Dispenses through a valid/ready handshake, then returns change or a cancel refund.
//  Sits between the coin acceptor front end and the dispenser/change-hopper back end.
// PARAMETERS
//  N_ITEMS      5                  number of selectable items (item_sel 1..N_ITEMS)
//  CREDIT_W     7                  width of credit/change/price values, in cents
//  QTY_W        2                  width of quantity fields
//  MAX_QTY      3                  largest quantity accepted per purchase
//  MAX_CREDIT   95                 credit ceiling in cents; coins that would exceed it are rejected
//  ITEM_PRICES  {30,25,20,15,10}   packed N_ITEMS*CREDIT_W prices; item 1 in the LSBs
//  INV_W        4                  stock counter width (VEND_INVENTORY_EN only)
//  INV_INIT     7                  per-item stock after reset (VEND_INVENTORY_EN only)
// PORTS
//  clk           in   1                   clock, rising edge
//  rst           in   1                   asynchronous, active-high reset
//  coin          in   3                   one-hot {quarter,dime,nickel}; one insertion per non-zero cycle
//  item_sel      in   $clog2(N_ITEMS+1)   item index; 0 = none
//  qty_sel       in   QTY_W               requested quantity
//  confirm       in   1                   purchase request, sampled in IDLE/COLLECT
//  cancel        in   1                   refund request, sampled in IDLE/COLLECT
//  disp_ready    in   1                   dispenser accepts the current order
//  disp_valid    out  1                   order presented to the dispenser
//  disp_item     out  $clog2(N_ITEMS+1)   latched item index
//  disp_qty      out  QTY_W               latched quantity
//  change_valid  out  1                   one-cycle pulse; change is valid
//  change        out  CREDIT_W            change or refund amount
//  credit        out  CREDIT_W            current accumulated credit
//  coin_reject   out  1                   one-cycle pulse; last coin returned, not counted
//  err           out  1                   one-cycle pulse; confirm refused
// BEHAVIOUR
//  Reset: state=IDLE; every output and the credit register go to 0 immediately, including mid-transaction.
//  States:
//   IDLE     credit==0; an accepted coin -> COLLECT.
//   COLLECT  accepts coins. A valid confirm -> DISPENSE. cancel -> CHANGE (refund).
//   DISPENSE disp_valid=1. disp_item/disp_qty are held stable until disp_ready is sampled high.
//            On that handshake cycle -> CHANGE.
//   CHANGE   change_valid=1 for exactly 1 cycle, including when change==0.
//            credit<=0 in the same cycle; -> IDLE next cycle.
//  Coin handling:
//   - Value is 5/10/25. credit updates one cycle after the coin is sampled.
//   - Rejected when coin is multi-hot, when credit+value>MAX_CREDIT, or when the state is DISPENSE/CHANGE.
//   - Also rejected when confirm or cancel is high in the same cycle.
//   - A rejected coin leaves credit unchanged and pulses coin_reject the next cycle.
//  Confirm handling:
//   - cost = price[item_sel-1]*qty_sel, computed at CREDIT_W+QTY_W bits with no truncation.
//   - Refused with an err pulse (state and credit unchanged) when item_sel==0, item_sel>N_ITEMS,
//     qty_sel==0, qty_sel>MAX_QTY, or cost>credit.
//   - Accepted: latch item, qty and change=credit-cost, then -> DISPENSE.
//  Priorities and ignored requests:
//   - cancel beats confirm in the same cycle.
//   - cancel and confirm are ignored in DISPENSE and CHANGE (purchase already committed).
//   - confirm or cancel in IDLE: confirm gives err (cost>0); cancel gives a change_valid pulse with change=0.
//  Latency: coin to credit 1 cycle; confirm to disp_valid 1 cycle; handshake to change_valid 1 cycle.
// CONFIGURATION
//  VEND_INVENTORY_EN defined:
//   - Per-item INV_W stock counters, set to INV_INIT on reset.
//   - Adds output sold_out[N_ITEMS-1:0]; bit i-1 is high while stock of item i is 0.
//   - confirm is also refused (err) when stock<qty_sel.
//   - Stock decrements by disp_qty on the disp_valid&disp_ready cycle.
//  VEND_INVENTORY_EN undefined: stock is unlimited; no counters; sold_out port absent.
// TESTING
//  1) dime,dime,nickel (credit 25); item 4 qty 1 confirm; disp_ready held low 3 cycles then high
//     -> disp_valid held 4 cycles with item 4; change_valid with change=0; credit=0.
//  2) quarter,quarter (credit 50); item 1 qty 3 confirm
//     -> disp_qty=3; change=20 one cycle after handshake; back to IDLE.
//  3) credit 10; item 5 qty 1 confirm -> err pulse, credit stays 10.
//     Then cancel -> change_valid, change=10, credit 0.
//  4) coin=3'b011 -> coin_reject, credit unchanged.
//     Credit 90 + dime -> coin_reject, credit 90. Coin with confirm -> coin_reject.
//  5) rst asserted mid-DISPENSE, no clock edge -> disp_valid, credit, change at 0 immediately;
//     IDLE after release.
//  6) [VEND_INVENTORY_EN, INV_INIT=2] buy item 3 qty 2 -> sold_out[2]=1.
//     Then item 3 qty 1 with credit 20 -> err, credit kept.

Source files
------------

// File: rtl/vend_ctrl_param_if.sv
// Vending controller bus: coin and selection inputs from the coin acceptor front end,
// dispense handshake and change outputs toward the dispenser/change-hopper back end.
interface vend_ctrl_param_if #(
  parameter int N_ITEMS  = 5,
  parameter int CREDIT_W = 7,
  parameter int QTY_W    = 2
);
  localparam int SEL_W = $clog2(N_ITEMS + 1);

  logic [2:0]          coin;
  logic [SEL_W-1:0]    item_sel;
  logic [QTY_W-1:0]    qty_sel;
  logic                confirm;
  logic                cancel;
  logic                disp_ready;
  logic                disp_valid;
  logic [SEL_W-1:0]    disp_item;
  logic [QTY_W-1:0]    disp_qty;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                err;

  modport master (
    output coin, item_sel, qty_sel, confirm, cancel, disp_ready,
    input  disp_valid, disp_item, disp_qty, change_valid, change, credit, coin_reject, err
  );

  modport slave (
    input  coin, item_sel, qty_sel, confirm, cancel, disp_ready,
    output disp_valid, disp_item, disp_qty, change_valid, change, credit, coin_reject, err
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller: coin credit, priced multi-quantity purchase,
// valid/ready dispense, then change/refund. Define VEND_INVENTORY_EN for per-item stock.
module vend_ctrl_param #(
  parameter int N_ITEMS    = 5,
  parameter int CREDIT_W   = 7,
  parameter int QTY_W      = 2,
  parameter int MAX_QTY    = 3,
  parameter int MAX_CREDIT = 95,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {7'd30, 7'd25, 7'd20, 7'd15, 7'd10},
  parameter int INV_W      = 4,
  parameter int INV_INIT   = 7
) (
  input  logic clk,
  input  logic rst,
`ifdef VEND_INVENTORY_EN
  output logic [N_ITEMS-1:0] sold_out,
`endif
  vend_ctrl_param_if.slave bus
);
  localparam int SEL_W  = $clog2(N_ITEMS + 1);
  localparam int COST_W = CREDIT_W + QTY_W;
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic [CREDIT_W-1:0] change_q, change_nxt;
  logic [SEL_W-1:0]    item_q, item_nxt;
  logic [QTY_W-1:0]    qty_q, qty_nxt;
  logic                coin_reject_q, coin_reject_nxt;
  logic                err_q, err_nxt;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic [COST_W-1:0]   cost;
  logic                open_st, coin_ok, sel_ok, qty_ok, stock_ok, buy_ok;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] c);
    case (c)
      3'b001:  coin_value = CREDIT_W'(5);
      3'b010:  coin_value = CREDIT_W'(10);
      3'b100:  coin_value = CREDIT_W'(25);
      default: coin_value = '0;   // none or multi-hot
    endcase
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] sel);
    price_of = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (sel == SEL_W'(i + 1)) price_of = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
  endfunction

`ifdef VEND_INVENTORY_EN
  logic [INV_W-1:0] stock_q [N_ITEMS];
  logic [INV_W-1:0] stock_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= INV_W'(INV_INIT);
    end else if (state == DISPENSE && bus.disp_ready) begin
      for (int i = 0; i < N_ITEMS; i++)
        if (item_q == SEL_W'(i + 1)) stock_q[i] <= stock_q[i] - INV_W'(qty_q);
    end
  end

  always_comb begin
    stock_sel = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      sold_out[i] = (stock_q[i] == '0);
      if (bus.item_sel == SEL_W'(i + 1)) stock_sel = stock_q[i];
    end
  end

  assign stock_ok = int'(stock_sel) >= int'(bus.qty_sel);
`else
  logic unused_inv_cfg;
  assign unused_inv_cfg = (INV_W > 0) && (INV_INIT >= 0);
  assign stock_ok       = 1'b1;
`endif

  // Request qualification: coin acceptance and purchase validity
  assign open_st  = (state == IDLE) || (state == COLLECT);
  assign coin_val = coin_value(bus.coin);
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok  = open_st && !bus.confirm && !bus.cancel && (coin_val != '0) && (coin_sum <= MAX_C);
  assign cost     = {{QTY_W{1'b0}}, price_of(bus.item_sel)} * {{CREDIT_W{1'b0}}, bus.qty_sel};
  assign sel_ok   = (bus.item_sel != '0) && (int'(bus.item_sel) <= N_ITEMS);
  assign qty_ok   = (bus.qty_sel != '0) && (int'(bus.qty_sel) <= MAX_QTY);
  assign buy_ok   = sel_ok && qty_ok && stock_ok && (cost <= {{QTY_W{1'b0}}, credit_q});

  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit_q;
    change_nxt      = change_q;
    item_nxt        = item_q;
    qty_nxt         = qty_q;
    err_nxt         = 1'b0;
    coin_reject_nxt = (bus.coin != 3'b000) && !coin_ok;
    case (state)
      IDLE, COLLECT: begin
        if (bus.cancel) begin
          change_nxt = credit_q;
          credit_nxt = '0;
          state_nxt  = CHANGE;
        end else if (bus.confirm) begin
          if (buy_ok) begin
            item_nxt   = bus.item_sel;
            qty_nxt    = bus.qty_sel;
            change_nxt = credit_q - cost[CREDIT_W-1:0];
            state_nxt  = DISPENSE;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (coin_ok) begin
          credit_nxt = coin_sum[CREDIT_W-1:0];
          state_nxt  = COLLECT;
        end
      end
      DISPENSE: begin
        if (bus.disp_ready) begin
          credit_nxt = '0;
          state_nxt  = CHANGE;
        end
      end
      CHANGE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: every output is cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      credit_q      <= '0;
      change_q      <= '0;
      item_q        <= '0;
      qty_q         <= '0;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit_q      <= credit_nxt;
      change_q      <= change_nxt;
      item_q        <= item_nxt;
      qty_q         <= qty_nxt;
      coin_reject_q <= coin_reject_nxt;
      err_q         <= err_nxt;
    end
  end

  assign bus.disp_valid   = (state == DISPENSE);
  assign bus.change_valid = (state == CHANGE);
  assign bus.disp_item    = item_q;
  assign bus.disp_qty     = qty_q;
  assign bus.change       = change_q;
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: directed purchase/refund/reject scenarios plus random traffic
// checked every cycle against a transaction-level model of the vending rules.
module tb_vend_ctrl_param;
`ifdef VEND_INVENTORY_EN
  localparam int INV_INIT_TB = 2;
`else
  localparam int INV_INIT_TB = 7;
`endif
  localparam logic [2:0] NICKEL = 3'b001, DIME = 3'b010, QUARTER = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vend_ctrl_param_if #(.N_ITEMS(5), .CREDIT_W(7), .QTY_W(2)) bus ();
`ifdef VEND_INVENTORY_EN
  logic [4:0] sold_out;
`endif

  vend_ctrl_param #(.INV_INIT(INV_INIT_TB)) dut (
    .clk(clk),
    .rst(rst),
`ifdef VEND_INVENTORY_EN
    .sold_out(sold_out),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: credit balance, an open order, a change payout due.
  int price_tab [5] = '{10, 15, 20, 25, 30};
  int m_credit, m_item, m_qty, m_change;
  bit m_ordering, m_paying, m_reject, m_err;
  int m_stock [5];

  always @(posedge clk or posedge rst) begin : model
    int cv, cost, it, q;
    bit open, took_coin, ok;
    if (rst) begin
      m_credit = 0; m_item = 0; m_qty = 0; m_change = 0;
      m_ordering = 0; m_paying = 0; m_reject = 0; m_err = 0;
      for (int i = 0; i < 5; i++) m_stock[i] = INV_INIT_TB;
    end else begin
      open = !m_ordering && !m_paying;
      it = int'(bus.item_sel);
      q  = int'(bus.qty_sel);
      cv = (bus.coin == NICKEL) ? 5 : (bus.coin == DIME) ? 10 : (bus.coin == QUARTER) ? 25 : 0;
      took_coin = 0;
      m_err = 0;
      if (m_paying) begin
        m_paying = 0;
      end else if (m_ordering) begin
        if (bus.disp_ready) begin
          m_ordering = 0;
          m_paying   = 1;
          m_credit   = 0;
`ifdef VEND_INVENTORY_EN
          m_stock[m_item-1] -= m_qty;
`endif
        end
      end else if (bus.cancel) begin
        m_change = m_credit;
        m_credit = 0;
        m_paying = 1;
      end else if (bus.confirm) begin
        ok = (it >= 1) && (it <= 5) && (q >= 1) && (q <= 3);
        cost = ok ? price_tab[it-1] * q : 0;
        ok = ok && (cost <= m_credit);
`ifdef VEND_INVENTORY_EN
        ok = ok && (m_stock[it-1] >= q);
`endif
        if (ok) begin
          m_item = it; m_qty = q; m_change = m_credit - cost; m_ordering = 1;
        end else begin
          m_err = 1;
        end
      end else if (open && cv != 0 && m_credit + cv <= 95) begin
        m_credit += cv;
        took_coin = 1;
      end
      m_reject = (bus.coin != 3'b000) && !took_coin;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("credit", 32'(bus.credit), 32'(m_credit));
      chk("disp_valid", 32'(bus.disp_valid), 32'(m_ordering));
      chk("change_valid", 32'(bus.change_valid), 32'(m_paying));
      chk("coin_reject", 32'(bus.coin_reject), 32'(m_reject));
      chk("err", 32'(bus.err), 32'(m_err));
      if (m_ordering) begin
        chk("disp_item", 32'(bus.disp_item), 32'(m_item));
        chk("disp_qty", 32'(bus.disp_qty), 32'(m_qty));
      end
      if (m_paying) chk("change", 32'(bus.change), 32'(m_change));
`ifdef VEND_INVENTORY_EN
      for (int i = 0; i < 5; i++) chk("sold_out", 32'(sold_out[i]), 32'(m_stock[i] == 0));
`endif
    end
  end

  // Apply one cycle of inputs; return 1ns after the edge that sampled them.
  task automatic put(input logic [2:0] c, input int it, input int q,
                     input bit cf, input bit cn, input bit rd);
    @(negedge clk);
    bus.coin = c; bus.item_sel = 3'(it); bus.qty_sel = 2'(q);
    bus.confirm = cf; bus.cancel = cn; bus.disp_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    put(3'b000, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [2:0] c;
    bus.coin = 3'b000; bus.item_sel = '0; bus.qty_sel = '0;
    bus.confirm = 0; bus.cancel = 0; bus.disp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 0);
    chk("rst_change_valid", 32'(bus.change_valid), 0);
    chk("rst_err", 32'(bus.err), 0);

    // 1) 25 cents, item 4, dispenser stalls three cycles
    put(DIME, 0, 0, 0, 0, 0); put(DIME, 0, 0, 0, 0, 0); put(NICKEL, 0, 0, 0, 0, 0);
    chk("s1_credit", 32'(bus.credit), 25);
    put(3'b000, 4, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("s1_disp_valid", 32'(bus.disp_valid), 1);
      chk("s1_disp_item", 32'(bus.disp_item), 4);
      put(3'b000, 0, 0, 0, 0, (k == 3));
    end
    chk("s1_change_valid", 32'(bus.change_valid), 1);
    chk("s1_change", 32'(bus.change), 0);
    chk("s1_credit0", 32'(bus.credit), 0);
    idle();
    chk("s1_pulse_end", 32'(bus.change_valid), 0);

    // 2) 50 cents, item 1 x3, change 20
    put(QUARTER, 0, 0, 0, 0, 0); put(QUARTER, 0, 0, 0, 0, 0);
    chk("s2_credit", 32'(bus.credit), 50);
    put(3'b000, 1, 3, 1, 0, 1);
    chk("s2_disp_qty", 32'(bus.disp_qty), 3);
    put(3'b000, 0, 0, 0, 0, 1);
    chk("s2_change", 32'(bus.change), 20);
    chk("s2_change_valid", 32'(bus.change_valid), 1);
    idle();
    chk("s2_idle_credit", 32'(bus.credit), 0);

    // 3) insufficient credit refused, then cancel refunds
    put(DIME, 0, 0, 0, 0, 0);
    put(3'b000, 5, 1, 1, 0, 0);
    chk("s3_err", 32'(bus.err), 1);
    chk("s3_credit", 32'(bus.credit), 10);
    put(3'b000, 0, 0, 0, 1, 0);
    chk("s3_refund_valid", 32'(bus.change_valid), 1);
    chk("s3_refund", 32'(bus.change), 10);
    chk("s3_credit0", 32'(bus.credit), 0);
    idle();

    // 4) coin rejections: multi-hot, over ceiling, coin alongside confirm
    put(3'b011, 0, 0, 0, 0, 0);
    chk("s4_multihot", 32'(bus.coin_reject), 1);
    chk("s4_credit0", 32'(bus.credit), 0);
    put(QUARTER, 0, 0, 0, 0, 0); put(QUARTER, 0, 0, 0, 0, 0); put(QUARTER, 0, 0, 0, 0, 0);
    put(DIME, 0, 0, 0, 0, 0); put(NICKEL, 0, 0, 0, 0, 0);
    chk("s4_credit90", 32'(bus.credit), 90);
    put(DIME, 0, 0, 0, 0, 0);
    chk("s4_ceiling", 32'(bus.coin_reject), 1);
    chk("s4_credit_kept", 32'(bus.credit), 90);
    put(NICKEL, 0, 0, 1, 0, 0);
    chk("s4_with_confirm", 32'(bus.coin_reject), 1);
    chk("s4_credit_kept2", 32'(bus.credit), 90);
    put(3'b000, 0, 0, 0, 1, 0);
    chk("s4_refund", 32'(bus.change), 90);
    idle();

    // 5) asynchronous reset in the middle of a dispense
    put(DIME, 0, 0, 0, 0, 0); put(DIME, 0, 0, 0, 0, 0);
    put(3'b000, 2, 1, 1, 0, 0);
    chk("s5_dispensing", 32'(bus.disp_valid), 1);
    #2 rst = 1;
    #1;
    chk("s5_rst_disp_valid", 32'(bus.disp_valid), 0);
    chk("s5_rst_credit", 32'(bus.credit), 0);
    chk("s5_rst_change", 32'(bus.change), 0);
    @(negedge clk);
    rst = 0;
    put(NICKEL, 0, 0, 0, 0, 0);
    chk("s5_after_credit", 32'(bus.credit), 5);
    chk("s5_after_disp", 32'(bus.disp_valid), 0);
    put(3'b000, 0, 0, 0, 1, 0);
    idle();

`ifdef VEND_INVENTORY_EN
    // 6) stock of item 3 runs out
    put(QUARTER, 0, 0, 0, 0, 0); put(DIME, 0, 0, 0, 0, 0); put(NICKEL, 0, 0, 0, 0, 0);
    put(3'b000, 3, 2, 1, 0, 1);
    put(3'b000, 0, 0, 0, 0, 1);
    idle();
    chk("s6_sold_out", 32'(sold_out[2]), 1);
    put(DIME, 0, 0, 0, 0, 0); put(DIME, 0, 0, 0, 0, 0);
    put(3'b000, 3, 1, 1, 0, 0);
    chk("s6_err", 32'(bus.err), 1);
    chk("s6_credit", 32'(bus.credit), 20);
    put(3'b000, 0, 0, 0, 1, 0);
    idle();
`endif

    // Random traffic, checked by the per-cycle model comparison
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    c = NICKEL;
        2:       c = DIME;
        3:       c = QUARTER;
        4:       c = 3'($urandom_range(0, 7));
        default: c = 3'b000;
      endcase
      put(c, $urandom_range(0, 7), $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1);
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
